data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the cpu data port (READ/WRITE/ALURESULT/REGOUT1/READDATA/BUSYWAIT) and data_memory.
- Hits are serviced without stalling the cpu. Misses stall the cpu via BUSYWAIT while the cache writes back a dirty block and fetches a 4-byte block from data_memory over a 32-bit block interface.

Parameters:
- INDEX_W, 3, index bits; cache holds 2**INDEX_W blocks. Tag width = 8 - 2 - INDEX_W.
- BLOCK_BYTES, 4, bytes per block; fixed and not overridable in this revision. Offset = ADDRESS[1:0].

Ports:
- CLK  input  1  system clock; all state updates on posedge
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK
- READ  input  1  cpu load request
- WRITE  input  1  cpu store request
- ADDRESS  input  8  cpu byte address {tag, index, offset}
- WRITEDATA  input  8  cpu store data
- READDATA  output  8  load data, combinational from the selected block on a hit
- BUSYWAIT  output  1  stall to cpu
- MEM_READ  output  1  block fetch strobe to data_memory
- MEM_WRITE  output  1  block write-back strobe to data_memory
- MEM_ADDRESS  output  6  block address {tag, index}
- MEM_WRITEDATA  output  32  write-back block; byte0 at [7:0]
- MEM_READDATA  input  32  fetched block; byte0 at [7:0]
- MEM_BUSYWAIT  input  1  data_memory busy

Behaviour:
- Storage: per block, valid, dirty, tag and 32-bit data.
- hit = valid[idx] && tag[idx]==ADDRESS tag.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- BUSYWAIT = (state!=IDLE) || ((READ||WRITE) && !hit). Combinational, so it rises in the same cycle as a missing request.
- Read hit in IDLE: READDATA = selected byte in the same cycle, BUSYWAIT=0, no state change.
- Write hit in IDLE: on the next posedge, the byte at the offset is written and dirty[idx] is set. BUSYWAIT=0.
- READ and WRITE both high: treated as WRITE.
- Miss in IDLE:
  - dirty[idx]=1: next state WRITEBACK.
  - dirty[idx]=0: next state FETCH.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, idx}, MEM_WRITEDATA=stored block.
  - Leave to FETCH on the first posedge with MEM_BUSYWAIT==0, not counting the first cycle in the state.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={request tag, idx}.
  - Leave to UPDATE under the same rule as WRITEBACK.
- UPDATE (one cycle): data[idx]<=MEM_READDATA, tag updated, valid=1, dirty=0, then go to IDLE.
  - The still-held request then hits: a read returns data, a write updates the byte and sets dirty.
- MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE and UPDATE.
- The cpu holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1. The cache does not latch them.
- Reset, including mid-miss:
  - state=IDLE; all valid and dirty cleared.
  - MEM_READ=MEM_WRITE=0; MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - READDATA and BUSYWAIT follow the combinational rules, so with READ=WRITE=0 both are 0.
  - Dirty contents are discarded with no write-back.
- Min miss latency with a clean victim: FETCH cycles + 1 UPDATE cycle + the hit cycle.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds output ports HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset to 0.
  - HIT_COUNT increments once per request that hits on first presentation in IDLE.
  - MISS_COUNT increments once per request on the IDLE->WRITEBACK/FETCH transition.
  - Both saturate at 16'hFFFF.
  - The hit that completes a miss is not counted as a hit.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then READ addr 8'h14 with memory block 5 = 32'hDDCCBBAA:
  - BUSYWAIT=1 immediately; MEM_READ=1 with MEM_ADDRESS=6'h05.
  - After UPDATE: READDATA=8'hAA, BUSYWAIT=0.
- Next, READ 8'h17 → READDATA=8'hDD in the same cycle, BUSYWAIT=0, no MEM_READ.
- WRITE 8'h15 data 8'h55 (hit) → no stall. Subsequent READ 8'h15 returns 8'h55.
- READ 8'h34 (same index 5, tag differs, victim dirty):
  - WRITEBACK first: MEM_WRITE=1, MEM_ADDRESS=6'h05, MEM_WRITEDATA=32'hDDCC55AA.
  - Then FETCH with MEM_ADDRESS=6'h0D.
- Assert RESET during FETCH → next posedge: state IDLE, MEM_READ=0. Re-READ 8'h14 misses, proving valid was cleared.
- With DCACHE_STATS_EN: run the sequence above without the reset step → HIT_COUNT=3, MISS_COUNT=2.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the cpu data port and data_memory.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module data_cache #(
    parameter int unsigned INDEX_W = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    localparam int unsigned BLOCK_BYTES = 4;
    localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);
    localparam int unsigned NUM_BLOCKS  = 1 << INDEX_W;
    localparam int unsigned TAG_W       = 8 - OFFSET_W - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t state_q, state_d;
    logic   first_q;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [31:0]           data_q [NUM_BLOCKS];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    req_tag;
    logic [OFFSET_W-1:0] offset;
    logic [31:0]         cur_block;
    logic                req;
    logic                hit;
    logic                write_hit;
    logic                wait_done;

    logic        mem_read_d;
    logic        mem_write_d;
    logic [5:0]  mem_address_d;
    logic [31:0] mem_writedata_d;

    assign idx       = ADDRESS[OFFSET_W +: INDEX_W];
    assign req_tag   = ADDRESS[7 -: TAG_W];
    assign offset    = ADDRESS[OFFSET_W-1:0];
    assign cur_block = data_q[idx];
    assign req       = READ || WRITE;
    assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
    assign write_hit = (state_q == IDLE) && WRITE && hit;
    // Memory busy is ignored in the first cycle of a transfer, before memory has seen the strobe.
    assign wait_done = !first_q && !MEM_BUSYWAIT;

    assign BUSYWAIT = (state_q != IDLE) || (req && !hit);
    assign READDATA = (READ && hit) ? cur_block[{offset, 3'b000} +: 8] : 8'h00;

    // Next state and next memory-interface values.
    always_comb begin
        state_d         = state_q;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_address_d   = 6'h00;
        mem_writedata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = dirty_q[idx] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: if (wait_done) state_d = FETCH;
            FETCH:     if (wait_done) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (state_d == WRITEBACK) begin
            mem_write_d     = 1'b1;
            mem_address_d   = {tag_q[idx], idx};
            mem_writedata_d = cur_block;
        end else if (state_d == FETCH) begin
            mem_read_d    = 1'b1;
            mem_address_d = {req_tag, idx};
        end
    end

    // State, block status bits and registered memory strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            first_q       <= 1'b0;
            valid_q       <= '0;
            dirty_q       <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= 6'h00;
            MEM_WRITEDATA <= 32'h0;
        end else begin
            state_q       <= state_d;
            first_q       <= (state_d != state_q) &&
                             ((state_d == WRITEBACK) || (state_d == FETCH));
            MEM_READ      <= mem_read_d;
            MEM_WRITE     <= mem_write_d;
            MEM_ADDRESS   <= mem_address_d;
            MEM_WRITEDATA <= mem_writedata_d;
            if (state_q == UPDATE) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (write_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid gates their use.
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            data_q[idx] <= MEM_READDATA;
            tag_q[idx]  <= req_tag;
        end else if (write_hit) begin
            data_q[idx][{offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        after_update_q;

    // The hit that closes a miss arrives right after UPDATE and is not a fresh request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q      <= 16'h0;
            miss_cnt_q     <= 16'h0;
            after_update_q <= 1'b0;
        end else begin
            after_update_q <= (state_q == UPDATE);
            if ((state_q == IDLE) && req && hit && !after_update_q &&
                (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if ((state_q == IDLE) && (state_d != IDLE) && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
